// File: rtl/wb_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_ctrl
// Purpose  : Writeback stage controller. Captures one retiring instruction
//            from MEM; ALU results are written back one cycle later, loads
//            wait for memory read data, which is byte/half aligned and
//            sign/zero extended before the register-file write. Provides the
//            load-pending stall and hazard info, and handles flush, load
//            timeout and misaligned/illegal load faults.
// Ports    : clk, reset (async, active-high)
//            stall, flush, in_valid, alu_in, alu_to_reg_in, is_load_in,
//            funct3_in, addr_lo_in, rd_in          - MEM stage entry
//            mem_rdata, mem_rvalid                 - memory read return
//            wb_data, wb_we, wb_rd                 - register-file write
//            wb_stall_req, ld_pending, ld_pending_rd - hazard unit info
//            load_fault (pulse), load_err (sticky) - load error reporting
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage_ctrl #(
  parameter int RA_W              = 5,
  parameter int LOAD_TIMEOUT      = 15,
  parameter bit ZERO_REG_SUPPRESS = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [31:0]     alu_in,
  input  logic            alu_to_reg_in,
  input  logic            is_load_in,
  input  logic [2:0]      funct3_in,
  input  logic [1:0]      addr_lo_in,
  input  logic [RA_W-1:0] rd_in,
  input  logic [31:0]     mem_rdata,
  input  logic            mem_rvalid,
  output logic [31:0]     wb_data,
  output logic            wb_we,
  output logic [RA_W-1:0] wb_rd,
  output logic            wb_stall_req,
  output logic            ld_pending,
  output logic [RA_W-1:0] ld_pending_rd,
  output logic            load_fault,
  output logic            load_err
);

  // Counter only has to reach LOAD_TIMEOUT-1.
  localparam int               CNT_W    = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_LD_WAIT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        held_f3;
  logic [1:0]        held_addr;
  logic [RA_W-1:0]   held_rd;
  logic [CNT_W-1:0]  cnt;

  logic              in_ld_wait;
  logic              capture;
  logic              in_illegal;
  logic              in_misaligned;
  logic              cap_fault;
  logic              cap_load_ok;
  logic              cap_alu;
  logic              ld_done;
  logic              ld_timeout;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [31:0]       ext_data;

  assign in_ld_wait = (state == ST_LD_WAIT);

  // Hold upstream while waiting for data, and also on the completion cycle
  // when an ALU entry is offered: the load write owns the write port then.
  assign wb_stall_req = in_ld_wait &
                        ((!mem_rvalid & !flush) | (mem_rvalid & in_valid & !is_load_in));
  assign ld_pending    = in_ld_wait;
  assign ld_pending_rd = held_rd;

  assign capture       = in_valid & !stall & !flush & !wb_stall_req;
  assign in_illegal    = (funct3_in == 3'b011) | (funct3_in == 3'b110) | (funct3_in == 3'b111);
  assign in_misaligned = ((funct3_in[1:0] == 2'b01) & addr_lo_in[0]) |
                         ((funct3_in == 3'b010) & (addr_lo_in != 2'b00));
  assign cap_fault     = capture & is_load_in & (in_illegal | in_misaligned);
  assign cap_load_ok   = capture & is_load_in & !(in_illegal | in_misaligned);
  assign cap_alu       = capture & !is_load_in;
  assign ld_done       = in_ld_wait & mem_rvalid & !flush;
  assign ld_timeout    = in_ld_wait & !mem_rvalid & !flush & (cnt == CNT_LAST);

  // Lane selection and extension of the returned word.
  always_comb begin
    sel_byte = mem_rdata[7:0];
    case (held_addr)
      2'd1:    sel_byte = mem_rdata[15:8];
      2'd2:    sel_byte = mem_rdata[23:16];
      2'd3:    sel_byte = mem_rdata[31:24];
      default: sel_byte = mem_rdata[7:0];
    endcase
    sel_half = held_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (held_f3)
      3'b000:  ext_data = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  ext_data = {24'd0, sel_byte};
      3'b001:  ext_data = {{16{sel_half[15]}}, sel_half};
      3'b101:  ext_data = {16'd0, sel_half};
      default: ext_data = mem_rdata;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cap_load_ok) state_nxt = ST_LD_WAIT;
      end
      ST_LD_WAIT: begin
        if (flush)            state_nxt = ST_IDLE;
        else if (mem_rvalid)  state_nxt = cap_load_ok ? ST_LD_WAIT : ST_IDLE;
        else if (ld_timeout)  state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Writeback datapath, held load info and timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_data    <= '0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      load_fault <= 1'b0;
      load_err   <= 1'b0;
      held_f3    <= '0;
      held_addr  <= '0;
      held_rd    <= '0;
      cnt        <= '0;
    end else begin
      wb_we      <= 1'b0;
      load_fault <= 1'b0;

      // cap_alu cannot coincide with ld_done: wb_stall_req blocks it.
      if (ld_done) begin
        wb_data <= ext_data;
        wb_rd   <= held_rd;
        wb_we   <= !(ZERO_REG_SUPPRESS && (held_rd == '0));
      end else if (cap_alu) begin
        wb_data <= alu_in;
        wb_rd   <= rd_in;
        wb_we   <= alu_to_reg_in & !(ZERO_REG_SUPPRESS && (rd_in == '0));
      end

      if (cap_fault) begin
        load_fault <= 1'b1;
      end else if (cap_load_ok) begin
        held_f3   <= funct3_in;
        held_addr <= addr_lo_in;
        held_rd   <= rd_in;
        cnt       <= '0;
      end else if (in_ld_wait && !mem_rvalid && !flush && !ld_timeout) begin
        cnt <= cnt + 1'b1;
      end

      if (ld_timeout) load_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage_ctrl
// Purpose  : Self-checking bench for wb_stage_ctrl. A reference model of the
//            writeback rules pushes the expected registered outputs for every
//            clock edge into a queue; a monitor pops and compares them on the
//            falling edge. Combinational hazard outputs are checked before
//            each edge against the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage_ctrl;

  localparam int LOAD_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [31:0] alu_in = '0;
  logic        alu_to_reg_in = 1'b0, is_load_in = 1'b0;
  logic [2:0]  funct3_in = '0;
  logic [1:0]  addr_lo_in = '0;
  logic [4:0]  rd_in = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] wb_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic        wb_stall_req, ld_pending;
  logic [4:0]  ld_pending_rd;
  logic        load_fault, load_err;

  wb_stage_ctrl #(.RA_W(5), .LOAD_TIMEOUT(LOAD_TIMEOUT), .ZERO_REG_SUPPRESS(1'b1)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_in(alu_in), .alu_to_reg_in(alu_to_reg_in), .is_load_in(is_load_in),
    .funct3_in(funct3_in), .addr_lo_in(addr_lo_in), .rd_in(rd_in),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .wb_data(wb_data), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_stall_req(wb_stall_req), .ld_pending(ld_pending), .ld_pending_rd(ld_pending_rd),
    .load_fault(load_fault), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        we;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        fault;
    logic        err;
  } rec_t;

  rec_t        exp_q[$];
  bit          m_pend;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_addr;
  int          m_age;
  logic [31:0] e_data;
  logic [4:0]  e_rd;
  bit          e_err;

  function automatic logic [31:0] load_value(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] a);
    logic [31:0] sh;
    int          v;
    sh = word >> (8 * a);
    case (f3)
      3'b000:  begin v = $signed(sh[7:0]);  return v; end
      3'b001:  begin v = $signed(sh[15:0]); return v; end
      3'b100:  return sh & 32'h0000_00FF;
      3'b101:  return sh & 32'h0000_FFFF;
      default: return word;
    endcase
  endfunction

  function automatic bit is_fault(input logic [2:0] f3, input logic [1:0] a);
    int bytes;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    bytes = 1 << f3[1:0];
    return (int'(a) % bytes) != 0;
  endfunction

  function automatic bit exp_stall();
    return m_pend && ((!mem_rvalid && !flush) || (mem_rvalid && in_valid && !is_load_in));
  endfunction

  task automatic model_clear();
    m_pend = 0; m_rd = '0; m_f3 = '0; m_addr = '0; m_age = 0;
    e_data = '0; e_rd = '0; e_err = 0;
  endtask

  task automatic model_edge();
    rec_t r;
    bit   cap;
    r.we = 1'b0; r.fault = 1'b0;
    if (reset) begin
      model_clear();
    end else begin
      cap = in_valid && !stall && !flush && !exp_stall();
      if (m_pend) begin
        if (flush) m_pend = 0;
        else if (mem_rvalid) begin
          e_data = load_value(mem_rdata, m_f3, m_addr);
          e_rd   = m_rd;
          r.we   = (m_rd != 0);
          m_pend = 0;
        end else begin
          m_age++;
          if (m_age == LOAD_TIMEOUT) begin e_err = 1; m_pend = 0; end
        end
      end
      if (cap) begin
        if (!is_load_in) begin
          e_data = alu_in; e_rd = rd_in;
          r.we   = alu_to_reg_in && (rd_in != 0);
        end else if (is_fault(funct3_in, addr_lo_in)) begin
          r.fault = 1'b1;
        end else begin
          m_pend = 1; m_rd = rd_in; m_f3 = funct3_in; m_addr = addr_lo_in; m_age = 0;
        end
      end
    end
    r.data = e_data; r.rd = e_rd; r.err = e_err;
    exp_q.push_back(r);
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      model_edge();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        chk("wb_we",      wb_we,      r.we);
        chk("wb_data",    wb_data,    r.data);
        chk("wb_rd",      wb_rd,      r.rd);
        chk("load_fault", load_fault, r.fault);
        chk("load_err",   load_err,   r.err);
      end
    end
  end

  // ---------------- driver ----------------
  // Inputs are set at posedge+2; hazard outputs are checked at posedge+3.
  task automatic tick();
    #1;
    chk("wb_stall_req", wb_stall_req, exp_stall());
    chk("ld_pending",   ld_pending,   m_pend);
    if (m_pend) chk("ld_pending_rd", ld_pending_rd, m_rd);
    @(posedge clk);
    #2;
  endtask

  task automatic issue_alu(input logic [31:0] d, input logic [4:0] rd, input logic to_reg);
    in_valid = 1; is_load_in = 0; alu_in = d; rd_in = rd; alu_to_reg_in = to_reg;
    tick();
    in_valid = 0;
  endtask

  task automatic issue_load(input logic [2:0] f3, input logic [1:0] a, input logic [4:0] rd);
    in_valid = 1; is_load_in = 1; funct3_in = f3; addr_lo_in = a; rd_in = rd;
    tick();
    in_valid = 0; is_load_in = 0;
  endtask

  task automatic mem_resp(input logic [31:0] word, input int waits, output int nstall);
    nstall = 0;
    mem_rvalid = 0;
    for (int i = 0; i < waits; i++) begin
      #1 if (wb_stall_req) nstall++;
      tick();
    end
    mem_rvalid = 1; mem_rdata = word;
    tick();
    mem_rvalid = 0;
  endtask

  initial begin
    int n;
    // reset
    tick(); tick();
    reset = 0;
    tick();

    // ALU writeback, then rd=0 suppression
    issue_alu(32'hDEADBEEF, 5'd7, 1'b1);
    chk("alu_we", wb_we, 1'b1); chk("alu_rd", wb_rd, 5'd7); chk("alu_data", wb_data, 32'hDEADBEEF);
    issue_alu(32'h0000_1234, 5'd0, 1'b1);
    chk("alu_rd0_we", wb_we, 1'b0);
    tick();

    // LB / LBU / LH
    issue_load(3'b000, 2'd3, 5'd5);
    mem_resp(32'h80112233, 3, n);
    chk("lb_stall_cycles", n, 3);
    chk("lb_data", wb_data, 32'hFFFFFF80);
    issue_load(3'b100, 2'd3, 5'd6);
    mem_resp(32'h80112233, 2, n);
    chk("lbu_data", wb_data, 32'h00000080);
    issue_load(3'b001, 2'd2, 5'd8);
    mem_resp(32'h80112233, 1, n);
    chk("lh_data", wb_data, 32'hFFFF8011);

    // faults
    issue_load(3'b010, 2'd1, 5'd9);
    chk("lw_mis_fault", load_fault, 1'b1); chk("lw_mis_pend", ld_pending, 1'b0);
    tick();
    chk("fault_pulse_end", load_fault, 1'b0);
    issue_load(3'b011, 2'd0, 5'd9);
    chk("illegal_fault", load_fault, 1'b1);
    tick();

    // flush coinciding with mem_rvalid
    issue_load(3'b010, 2'd0, 5'd10);
    tick();
    flush = 1; mem_rvalid = 1; mem_rdata = 32'hAAAA5555;
    tick();
    flush = 0; mem_rvalid = 0;
    chk("flush_we", wb_we, 1'b0); chk("flush_pend", ld_pending, 1'b0);

    // back-to-back loads
    issue_load(3'b010, 2'd0, 5'd11);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h1357_9BDF;
    in_valid = 1; is_load_in = 1; funct3_in = 3'b000; addr_lo_in = 2'd1; rd_in = 5'd12;
    tick();
    in_valid = 0; is_load_in = 0; mem_rvalid = 0;
    chk("b2b_first_we", wb_we, 1'b1); chk("b2b_first_rd", wb_rd, 5'd11);
    chk("b2b_second_pend", ld_pending_rd, 5'd12);
    mem_resp(32'h0000_F000, 1, n);
    chk("b2b_second_data", wb_data, 32'hFFFFFFF0);

    // ALU entry offered on a completion cycle is held off one cycle
    issue_load(3'b010, 2'd0, 5'd13);
    mem_rvalid = 1; mem_rdata = 32'h0BAD_F00D;
    in_valid = 1; is_load_in = 0; alu_in = 32'h600D_600D; rd_in = 5'd14; alu_to_reg_in = 1;
    tick();
    mem_rvalid = 0;
    tick();
    in_valid = 0;
    tick();

    // timeout
    issue_load(3'b010, 2'd0, 5'd15);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!ld_pending) break;
      n++;
      tick();
    end
    chk("timeout_cycles", n, LOAD_TIMEOUT);
    chk("timeout_err", load_err, 1'b1);
    tick(); tick();
    chk("err_sticky", load_err, 1'b1);

    // async reset in the middle of LD_WAIT
    issue_load(3'b010, 2'd0, 5'd16);
    tick();
    @(negedge clk);
    #1 reset = 1;
    model_clear();
    #1;
    chk("arst_we", wb_we, 1'b0); chk("arst_data", wb_data, 32'h0);
    chk("arst_pend", ld_pending, 1'b0); chk("arst_err", load_err, 1'b0);
    chk("arst_stall", wb_stall_req, 1'b0);
    @(posedge clk);
    #2 reset = 0;
    tick();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      in_valid      = ($urandom_range(0, 99) < 60);
      is_load_in    = ($urandom_range(0, 99) < 50);
      alu_in        = $urandom;
      alu_to_reg_in = ($urandom_range(0, 99) < 85);
      rd_in         = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if ($urandom_range(0, 9) < 8) begin
        case ($urandom_range(0, 4))
          0: funct3_in = 3'b000;
          1: funct3_in = 3'b001;
          2: funct3_in = 3'b010;
          3: funct3_in = 3'b100;
          default: funct3_in = 3'b101;
        endcase
      end else begin
        funct3_in = 3'($urandom_range(0, 7));
      end
      addr_lo_in = 2'($urandom_range(0, 3));
      mem_rdata  = $urandom;
      mem_rvalid = ($urandom_range(0, 99) < 40);
      flush      = ($urandom_range(0, 99) < 5);
      stall      = ($urandom_range(0, 99) < 10);
      tick();
    end
    in_valid = 0; flush = 0; stall = 0; mem_rvalid = 0;
    tick(); tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_stage_ctrl.md
Name: wb_stage_ctrl

Overview:
- Parametrised successor to the MEM/WB writeback latch.
- Captures one retiring instruction from MEM. ALU results write back with 1-cycle latency.
- Loads wait in a small FSM for memory read data, which is then byte/half aligned and sign/zero extended before register-file write.
- Generates the load-pending stall and hazard info for the hazard unit; handles flush, load timeout and misaligned/illegal load faults.

Parameters:
- RA_W, 5, register address width.
- LOAD_TIMEOUT, 15, max cycles in LD_WAIT before abort; must be >=1.
- ZERO_REG_SUPPRESS, 1, when 1 writes to rd==0 are suppressed (wb_we forced 0).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  external stall; blocks capture of a new entry.
- flush  in  1  discard incoming entry and abort any pending load.
- in_valid  in  1  MEM stage presents a valid instruction.
- alu_in  in  32  ALU result.
- alu_to_reg_in  in  1  ALU result targets rd.
- is_load_in  in  1  instruction is a load.
- funct3_in  in  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- addr_lo_in  in  2  load address bits [1:0].
- rd_in  in  RA_W  destination register.
- mem_rdata  in  32  word-aligned memory read data.
- mem_rvalid  in  1  mem_rdata valid this cycle.
- wb_data  out  32  register-file write data (registered).
- wb_we  out  1  register-file write enable (registered, 1-cycle pulse per write).
- wb_rd  out  RA_W  register-file write address (registered).
- wb_stall_req  out  1  combinational; upstream must hold.
- ld_pending  out  1  combinational; a load is outstanding.
- ld_pending_rd  out  RA_W  rd of the outstanding load.
- load_fault  out  1  registered 1-cycle pulse: misaligned or illegal load.
- load_err  out  1  sticky: load timeout occurred.

Behaviour:
- Reset (async): state=IDLE, wb_data=0, wb_we=0, wb_rd=0, load_fault=0, load_err=0, timeout counter=0, held funct3/addr_lo/rd=0. Reset mid-LD_WAIT drops the load with no write.
- States:
  - IDLE: no load outstanding.
  - LD_WAIT: a load is captured and waiting for mem_rvalid.
- Capture condition at an edge: in_valid & !stall & !flush & !wb_stall_req.
- wb_stall_req = (state==LD_WAIT) & !mem_rvalid & !flush.
- ld_pending = (state==LD_WAIT); ld_pending_rd = held rd.
- Default each edge: wb_we<=0, load_fault<=0.
- ALU capture (is_load_in=0):
  - wb_data<=alu_in, wb_rd<=rd_in.
  - wb_we<=alu_to_reg_in & !(ZERO_REG_SUPPRESS & rd_in==0).
  - Latency 1 cycle.
- Load capture (is_load_in=1):
  - Fault check: misaligned (LH/LHU with addr_lo[0]=1, LW with addr_lo!=0) or funct3 in {011,110,111} -> load_fault<=1, no write, stay IDLE.
  - Otherwise latch funct3/addr_lo/rd, counter<=0, state<=LD_WAIT.
- LD_WAIT, mem_rvalid=1 & !flush:
  - wb_data<=extend(mem_rdata), wb_rd<=held rd, wb_we<=!(ZERO_REG_SUPPRESS & rd==0).
  - state<=IDLE.
  - wb_stall_req is 0 this cycle, so a new entry may be captured at the same edge. A captured ALU entry cannot also write that edge: load write has priority, and the new ALU entry is held and written the following edge. An implementation may instead block capture on completion cycles; chosen decision: wb_stall_req additionally asserts when state==LD_WAIT & mem_rvalid & in_valid & !is_load_in. A captured load enters LD_WAIT again directly.
- LD_WAIT, no mem_rvalid:
  - counter++.
  - When counter==LOAD_TIMEOUT-1 without mem_rvalid: load_err<=1 (sticky), state<=IDLE, no write.
- Extension:
  - LB/LBU select byte addr_lo*8; LH/LHU select half addr_lo[1]*16.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- flush:
  - Highest priority after reset. No capture; LD_WAIT->IDLE with no write even if mem_rvalid same cycle; load_fault not raised.
  - A wb_we already registered for the prior edge is unaffected.
- stall in LD_WAIT: ignored (load completes normally).

Test Plan:
- ALU capture alu_in=0xDEADBEEF, rd=7, alu_to_reg=1 -> next cycle wb_we=1, wb_rd=7, wb_data=0xDEADBEEF; repeat with rd=0 -> wb_we=0.
- LB addr_lo=3, mem_rdata=0x80112233 after 3 wait cycles -> wb_stall_req=1 for 3 cycles, then wb_data=0xFFFFFF80; LBU same -> 0x00000080; LH addr_lo=2 -> 0xFFFF8011.
- LW addr_lo=1 -> load_fault pulses 1 cycle, no wb_we, state stays IDLE; funct3=011 -> same.
- Load with mem_rvalid never asserted, LOAD_TIMEOUT=15 -> load_err rises after 15 cycles in LD_WAIT, wb_stall_req drops, no write; load_err stays high until reset.
- flush in LD_WAIT coinciding with mem_rvalid -> no wb_we, state IDLE; async reset mid-LD_WAIT -> all outputs 0 immediately.
- Back-to-back loads, second in_valid on completion cycle -> first writes, second enters LD_WAIT with no lost or duplicated write.
